// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, mode constants, idle levels and divider limits.
package spi_pkg;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_CS_SETUP = 2'd1;
   localparam logic [1:0] ST_SHIFT    = 2'd2;
   localparam logic [1:0] ST_CS_HOLD  = 2'd3;

   typedef enum logic [1:0] {
      IDLE     = ST_IDLE,
      CS_SETUP = ST_CS_SETUP,
      SHIFT    = ST_SHIFT,
      CS_HOLD  = ST_CS_HOLD
   } spi_state_e;

   localparam logic       SPI_CPOL    = 1'b0;
   localparam logic       SPI_CPHA    = 1'b0;
   localparam logic       MOSI_IDLE   = 1'b1;
   localparam logic [7:0] MIN_CLK_DIV = 8'd1;

   function automatic logic [7:0] clamp_div(input logic [7:0] d);
      return (d < MIN_CLK_DIV) ? MIN_CLK_DIV : d;
   endfunction

endpackage

// File: rtl/spi_master_if.sv
// Byte-level request/response bus between a client and spi_master.
interface spi_master_if;

   logic [7:0] i_tx_byte;
   logic       i_tx_valid;
   logic       o_tx_ready;
   logic       i_cs_keep;
   logic       i_cs_dummy;
   logic [7:0] o_rx_byte;
   logic       o_rx_valid;
   logic       o_busy;

   modport slave (
      input  i_tx_byte, i_tx_valid, i_cs_keep, i_cs_dummy,
      output o_tx_ready, o_rx_byte, o_rx_valid, o_busy
   );

   modport master (
      output i_tx_byte, i_tx_valid, i_cs_keep, i_cs_dummy,
      input  o_tx_ready, o_rx_byte, o_rx_valid, o_busy
   );

endinterface

// File: rtl/spi_sck_div.sv
// Half-period down-counter: ticks on the last cycle of each phase and reloads itself.
module spi_sck_div
   import spi_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       run_i,
   input  logic       load_i,
   input  logic [7:0] div_i,
   output logic       tick_o
);

   logic [7:0] cnt_q, cnt_d;

   assign tick_o = run_i && !load_i && (cnt_q <= MIN_CLK_DIV);

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = div_i;
      end else if (tick_o) begin
         cnt_d = div_i;
      end else if (run_i) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= MIN_CLK_DIV;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_master.sv
// Byte-oriented mode-0 SPI master with per-byte CS sequencing and CS-high dummy bytes.
// Optional SPI_MASTER_RUNTIME_DIV_EN adds a per-byte runtime divider input i_clk_div.
module spi_master
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic       i_clk,
   input  logic       i_sys_rst,
`ifdef SPI_MASTER_RUNTIME_DIV_EN
   input  logic [7:0] i_clk_div,
`endif
   spi_master_if.slave bus,
   output logic       o_sck,
   output logic       o_mosi,
   input  logic       i_miso,
   output logic       o_cs_n
);

   spi_state_e state_q, state_d;
   logic [7:0] tx_sr_q, tx_sr_d;
   logic [7:0] rx_sr_q, rx_sr_d;
   logic [7:0] rx_byte_q, rx_byte_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       rx_valid_q, rx_valid_d;
   logic       sck_q, sck_d;
   logic       cs_n_q, cs_n_d;
   logic       keep_q, keep_d;
   logic       dummy_q, dummy_d;

   logic       accept;
   logic       run;
   logic       tick;
   logic [7:0] div_load;

   assign accept = (state_q == IDLE) && bus.i_tx_valid;
   assign run    = (state_q != IDLE);

`ifdef SPI_MASTER_RUNTIME_DIV_EN
   logic [7:0] div_q, div_d;

   // The divider loads on the accept cycle itself, so it must see the new value combinationally.
   always_comb begin
      div_d = div_q;
      if (accept) begin
         div_d = clamp_div(i_clk_div);
      end
   end

   assign div_load = div_d;

   always_ff @(posedge i_clk or negedge i_sys_rst) begin
      if (!i_sys_rst) begin
         div_q <= clamp_div(8'(CLK_DIV));
      end else begin
         div_q <= div_d;
      end
   end
`else
   localparam logic [7:0] DIV_FIXED = clamp_div(8'(CLK_DIV));

   assign div_load = DIV_FIXED;
`endif

   spi_sck_div u_sck_div (
      .clk_i  (i_clk),
      .rst_ni (i_sys_rst),
      .run_i  (run),
      .load_i (accept),
      .div_i  (div_load),
      .tick_o (tick)
   );

   always_comb begin
      state_d    = state_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = 1'b0;
      bit_cnt_d  = bit_cnt_q;
      sck_d      = sck_q;
      cs_n_d     = cs_n_q;
      keep_d     = keep_q;
      dummy_d    = dummy_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               tx_sr_d   = bus.i_tx_byte;
               keep_d    = bus.i_cs_keep;
               dummy_d   = bus.i_cs_dummy;
               bit_cnt_d = '0;
               sck_d     = SPI_CPOL;
               if (bus.i_cs_dummy) begin
                  cs_n_d  = 1'b1;
                  state_d = SHIFT;
               end else if (cs_n_q) begin
                  cs_n_d  = 1'b0;
                  state_d = CS_SETUP;
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         CS_SETUP: begin
            if (tick) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (tick) begin
               if (sck_q == SPI_CPOL) begin
                  sck_d   = ~SPI_CPOL;
                  rx_sr_d = {rx_sr_q[6:0], i_miso};
               end else begin
                  sck_d = SPI_CPOL;
                  // The 8th falling edge completes the byte; rx_sr already holds bit 0.
                  if (bit_cnt_q == 3'd7) begin
                     rx_byte_d  = rx_sr_q;
                     rx_valid_d = 1'b1;
                     state_d    = (keep_q || dummy_q) ? IDLE : CS_HOLD;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                     tx_sr_d   = {tx_sr_q[6:0], 1'b0};
                  end
               end
            end
         end
         CS_HOLD: begin
            if (tick) begin
               cs_n_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_sys_rst) begin
      if (!i_sys_rst) begin
         state_q    <= IDLE;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
         bit_cnt_q  <= '0;
         sck_q      <= SPI_CPOL;
         cs_n_q     <= 1'b1;
         keep_q     <= 1'b0;
         dummy_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
         bit_cnt_q  <= bit_cnt_d;
         sck_q      <= sck_d;
         cs_n_q     <= cs_n_d;
         keep_q     <= keep_d;
         dummy_q    <= dummy_d;
      end
   end

   assign o_sck          = sck_q;
   assign o_mosi         = (state_q == CS_SETUP || state_q == SHIFT) ? tx_sr_q[7] : MOSI_IDLE;
   assign o_cs_n         = cs_n_q;
   assign bus.o_rx_byte  = rx_byte_q;
   assign bus.o_rx_valid = rx_valid_q;
   assign bus.o_tx_ready = (state_q == IDLE);
   assign bus.o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master (CLK_DIV=2), with extra runtime-divider cases.
module tb_spi_master;

   localparam int D = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic sck, mosi, miso, cs_n;
   logic       loop_en  = 1'b1;
   logic [7:0] slv_byte = 8'h00;
   int         miso_bits = 0;
   int         slv_base  = 0;
   logic [2:0] slv_idx;
`ifdef SPI_MASTER_RUNTIME_DIV_EN
   logic [7:0] clk_div = 8'd2;
`endif

   spi_master_if bus();

   spi_master #(.CLK_DIV(D)) dut (
      .i_clk     (clk),
      .i_sys_rst (rst_n),
`ifdef SPI_MASTER_RUNTIME_DIV_EN
      .i_clk_div (clk_div),
`endif
      .bus       (bus),
      .o_sck     (sck),
      .o_mosi    (mosi),
      .i_miso    (miso),
      .o_cs_n    (cs_n)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave model: presents the MSB first, advancing one bit per SCK rising edge.
   always @(posedge sck) miso_bits <= miso_bits + 1;
   always_comb slv_idx = 3'(7 - ((miso_bits - slv_base) & 7));
   assign miso = loop_en ? mosi : slv_byte[slv_idx];

   int acc_cnt = 0, acc_cyc = 0;
   int rise_cnt = 0, rxv_cnt = 0, cs_low_cnt = 0, cs_rise_cnt = 0;
   int cs_fall_cyc = -1, cs_rise_cyc = -1, ready_rise_cyc = -1;
   int rise_cyc_q[$];
   int rxv_cyc_q[$];
   logic [7:0] rx_q[$];
   logic prev_sck = 1'b0, prev_cs = 1'b1, prev_ready = 1'b1;

   always @(negedge clk) begin
      if (bus.i_tx_valid && bus.o_tx_ready) begin
         acc_cnt++;
         acc_cyc = cyc;
      end
      if (sck && !prev_sck) begin
         rise_cnt++;
         rise_cyc_q.push_back(cyc);
      end
      if (!cs_n) cs_low_cnt++;
      if (!cs_n && prev_cs) cs_fall_cyc = cyc;
      if (cs_n && !prev_cs) begin
         cs_rise_cyc = cyc;
         cs_rise_cnt++;
      end
      if (bus.o_tx_ready && !prev_ready) ready_rise_cyc = cyc;
      if (bus.o_rx_valid) begin
         rxv_cnt++;
         rxv_cyc_q.push_back(cyc);
         rx_q.push_back(bus.o_rx_byte);
      end
      prev_sck   = sck;
      prev_cs    = cs_n;
      prev_ready = bus.o_tx_ready;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic expire(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: bound expired, required event not seen", name);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_acc(input int a0, input int budget, input string name);
      int n = 0;
      while (acc_cnt == a0 && n < budget) begin step(1); n++; end
      if (acc_cnt == a0) expire(name);
   endtask

   task automatic wait_rxv(input int target, input int budget, input string name);
      int n = 0;
      while (rxv_cnt < target && n < budget) begin step(1); n++; end
      if (rxv_cnt < target) expire(name);
   endtask

   task automatic wait_rises(input int target, input int budget, input string name);
      int n = 0;
      while (rise_cnt < target && n < budget) begin step(1); n++; end
      if (rise_cnt < target) expire(name);
   endtask

   task automatic wait_ready(input int budget, input string name);
      int n = 0;
      while (!bus.o_tx_ready && n < budget) begin step(1); n++; end
      if (!bus.o_tx_ready) expire(name);
   endtask

   task automatic send(input logic [7:0] b, input logic keep, input logic dummy, output int t_acc);
      int a0;
      a0 = acc_cnt;
      slv_base = miso_bits;
      bus.i_tx_byte  = b;
      bus.i_cs_keep  = keep;
      bus.i_cs_dummy = dummy;
      bus.i_tx_valid = 1'b1;
      wait_acc(a0, 400, "accept");
      bus.i_tx_valid = 1'b0;
      t_acc = acc_cyc;
   endtask

   typedef struct {
      logic [7:0] tx;
      logic       dummy;
      logic       loopb;
      logic [7:0] slv;
      logic [7:0] exp_rx;
      int         exp_rxv;
      int         exp_fall;
      int         exp_rise;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t, t2, x0, r0, a0, c0, cr0;

      vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'h00, 8'hA5, 35, 1, 37};
      vecs[1] = '{8'h5A, 1'b0, 1'b1, 8'h00, 8'h5A, 35, 1, 37};
      vecs[2] = '{8'h00, 1'b0, 1'b0, 8'hC3, 8'hC3, 35, 1, 37};
      vecs[3] = '{8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 35, 1, 37};
      vecs[4] = '{8'h81, 1'b1, 1'b0, 8'h7E, 8'h7E, 33, 0, 0};
      vecs[5] = '{8'h3C, 1'b0, 1'b0, 8'h96, 8'h96, 35, 1, 37};

      bus.i_tx_valid = 1'b0;
      bus.i_tx_byte  = 8'h00;
      bus.i_cs_keep  = 1'b0;
      bus.i_cs_dummy = 1'b0;

      step(3);
      chk("rst_sck", int'(sck), 0);
      chk("rst_cs_n", int'(cs_n), 1);
      chk("rst_mosi", int'(mosi), 1);
      chk("rst_rx_byte", int'(bus.o_rx_byte), 0);
      chk("rst_rx_valid", int'(bus.o_rx_valid), 0);
      chk("rst_tx_ready", int'(bus.o_tx_ready), 1);
      chk("rst_busy", int'(bus.o_busy), 0);
      rst_n = 1'b1;
      step(2);

      for (int i = 0; i < 6; i++) begin
         loop_en  = vecs[i].loopb;
         slv_byte = vecs[i].slv;
         x0 = rxv_cnt; r0 = rise_cnt; c0 = cs_low_cnt;
         send(vecs[i].tx, 1'b0, vecs[i].dummy, t);
         wait_rxv(x0 + 1, 400, $sformatf("v%0d_rxv", i));
         wait_ready(100, $sformatf("v%0d_ready", i));
         step(3);
         chk($sformatf("v%0d_rx_byte", i), int'(bus.o_rx_byte), int'(vecs[i].exp_rx));
         chk($sformatf("v%0d_strobes", i), rxv_cnt - x0, 1);
         chk($sformatf("v%0d_rises", i), rise_cnt - r0, 8);
         if (rxv_cyc_q.size() > x0)
            chk($sformatf("v%0d_rxv_cycle", i), rxv_cyc_q[x0] - t, vecs[i].exp_rxv);
         if (vecs[i].dummy) begin
            chk($sformatf("v%0d_cs_low_cycles", i), cs_low_cnt - c0, 0);
         end else begin
            chk($sformatf("v%0d_cs_fall", i), cs_fall_cyc - t, vecs[i].exp_fall);
            chk($sformatf("v%0d_cs_rise", i), cs_rise_cyc - t, vecs[i].exp_rise);
            chk($sformatf("v%0d_ready_at_cs_rise", i), ready_rise_cyc, cs_rise_cyc);
         end
         if (rise_cyc_q.size() >= r0 + 8)
            chk($sformatf("v%0d_first_rise", i), rise_cyc_q[r0] - t,
                vecs[i].exp_rxv - 15 * D);
      end

      // Keep chain: second request is held so it is taken in the first IDLE cycle.
      loop_en = 1'b0; slv_byte = 8'h3C;
      x0 = rxv_cnt; r0 = rise_cnt; cr0 = cs_rise_cnt;
      send(8'h3C, 1'b1, 1'b0, t);
      a0 = acc_cnt;
      bus.i_tx_byte = 8'hFF; bus.i_cs_keep = 1'b0; bus.i_cs_dummy = 1'b0;
      bus.i_tx_valid = 1'b1;
      wait_acc(a0, 400, "chain_accept");
      bus.i_tx_valid = 1'b0;
      t2 = acc_cyc;
      wait_rxv(x0 + 2, 400, "chain_rxv");
      wait_ready(100, "chain_ready");
      step(3);
      chk("chain_rises", rise_cnt - r0, 16);
      chk("chain_cs_rises", cs_rise_cnt - cr0, 1);
      if (rx_q.size() >= x0 + 2 && rise_cyc_q.size() >= r0 + 16) begin
         chk("chain_rx0", int'(rx_q[x0]), 8'h3C);
         chk("chain_rx1", int'(rx_q[x0 + 1]), 8'h3C);
         chk("chain_accept_cycle", t2, rxv_cyc_q[x0]);
         chk("chain_low_phase", rise_cyc_q[r0 + 8] - rxv_cyc_q[x0], D + 1);
         chk("chain_rxv2", rxv_cyc_q[x0 + 1] - t2, 1 + 16 * D);
         chk("chain_cs_rise", cs_rise_cyc - rxv_cyc_q[x0 + 1], D);
      end

      // Ten CS-high dummy bytes, alternating keep to show it is ignored.
      loop_en = 1'b0; slv_byte = 8'h5A;
      x0 = rxv_cnt; r0 = rise_cnt; c0 = cs_low_cnt;
      for (int k = 0; k < 10; k++) begin
         send(8'hFF, 1'(k & 1), 1'b1, t);
         wait_rxv(x0 + k + 1, 400, "dummy_rxv");
      end
      wait_ready(100, "dummy_ready");
      step(3);
      chk("dummy_cs_low_cycles", cs_low_cnt - c0, 0);
      chk("dummy_rises", rise_cnt - r0, 80);
      chk("dummy_strobes", rxv_cnt - x0, 10);
      chk("dummy_rx_byte", int'(bus.o_rx_byte), 8'h5A);

      // Asynchronous reset while SCK is high after the 4th rising edge of 0x81.
      loop_en = 1'b1;
      x0 = rxv_cnt; r0 = rise_cnt;
      send(8'h81, 1'b0, 1'b0, t);
      wait_rises(r0 + 4, 200, "rstmid_rises");
      chk("rstmid_sck_before", int'(sck), 1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_sck", int'(sck), 0);
      chk("rstmid_cs_n", int'(cs_n), 1);
      chk("rstmid_mosi", int'(mosi), 1);
      chk("rstmid_ready", int'(bus.o_tx_ready), 1);
      step(2);
      rst_n = 1'b1;
      step(40);
      chk("rstmid_no_strobe", rxv_cnt - x0, 0);
      x0 = rxv_cnt; r0 = rise_cnt;
      send(8'h81, 1'b0, 1'b0, t);
      wait_rxv(x0 + 1, 400, "rstmid_fresh_rxv");
      wait_ready(100, "rstmid_fresh_ready");
      step(3);
      chk("rstmid_fresh_rx", int'(bus.o_rx_byte), 8'h81);
      chk("rstmid_fresh_rises", rise_cnt - r0, 8);
      if (rxv_cyc_q.size() > x0)
         chk("rstmid_fresh_rxv_cycle", rxv_cyc_q[x0] - t, 35);

      // Request pulsed during SHIFT must be ignored.
      loop_en = 1'b1;
      x0 = rxv_cnt; r0 = rise_cnt; a0 = acc_cnt;
      send(8'h5A, 1'b0, 1'b0, t);
      wait_rises(r0 + 2, 200, "pulse_rises");
      bus.i_tx_byte = 8'h00; bus.i_tx_valid = 1'b1;
      step(3);
      bus.i_tx_valid = 1'b0;
      wait_rxv(x0 + 1, 400, "pulse_rxv");
      wait_ready(100, "pulse_ready");
      step(40);
      chk("pulse_accepts", acc_cnt - a0, 1);
      chk("pulse_strobes", rxv_cnt - x0, 1);
      chk("pulse_rises", rise_cnt - r0, 8);
      chk("pulse_rx", int'(bus.o_rx_byte), 8'h5A);
      chk("pulse_busy", int'(bus.o_busy), 0);

`ifdef SPI_MASTER_RUNTIME_DIV_EN
      // Divider 0 behaves as 1: SCK period of 2 cycles.
      loop_en = 1'b1; clk_div = 8'd0;
      x0 = rxv_cnt; r0 = rise_cnt;
      send(8'hC3, 1'b0, 1'b0, t);
      wait_rxv(x0 + 1, 400, "div0_rxv");
      wait_ready(100, "div0_ready");
      step(3);
      chk("div0_rx", int'(bus.o_rx_byte), 8'hC3);
      if (rise_cyc_q.size() >= r0 + 8 && rxv_cyc_q.size() > x0) begin
         chk("div0_period", rise_cyc_q[r0 + 1] - rise_cyc_q[r0], 2);
         chk("div0_rxv_cycle", rxv_cyc_q[x0] - t, 18);
      end

      // Divider 60, changed mid-byte: the byte keeps its latched divider.
      clk_div = 8'd60;
      x0 = rxv_cnt; r0 = rise_cnt;
      send(8'h96, 1'b0, 1'b0, t);
      wait_rises(r0 + 2, 800, "div60_rises");
      clk_div = 8'd3;
      wait_rxv(x0 + 1, 3000, "div60_rxv");
      wait_ready(200, "div60_ready");
      step(3);
      chk("div60_rx", int'(bus.o_rx_byte), 8'h96);
      if (rise_cyc_q.size() >= r0 + 8 && rxv_cyc_q.size() > x0) begin
         chk("div60_period_first", rise_cyc_q[r0 + 1] - rise_cyc_q[r0], 120);
         chk("div60_period_last", rise_cyc_q[r0 + 7] - rise_cyc_q[r0 + 6], 120);
         chk("div60_rxv_cycle", rxv_cyc_q[x0] - t, 1021);
         chk("div60_cs_hold", cs_rise_cyc - rxv_cyc_q[x0], 60);
      end
      clk_div = 8'd2;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
